up_tpl_adc_pn_counters: RTL
===========================

Name: up_tpl_adc_pn_counters

Overview:
Parametrised per-channel PN-monitor statistics block for the TPL ADC register map. For each channel it counts PN error cycles and out-of-sync entries, keeps sticky error bits, and exposes them on the internal up register bus as its own 256-word address region. Its outputs are OR-combined with the other up slaves (common, channels, tpl_common), so it drives zero read data when not addressed. Per-channel pn_err/pn_oos inputs arrive already synchronised to up_clk.

Parameters:
NUM_CHANNELS, 1, channels monitored; legal range 1..64.
COUNTER_WIDTH, 32, width of each saturating counter; legal range 8..32; read back zero-extended to 32 bits.
ADDR_BASE, 14'h0600, region base in up word-address space; bits [7:0] must be zero.

Ports:
up_clk  input  1  register-bus clock; the only clock.
up_rstn  input  1  asynchronous, active-low reset.
pn_err  input  NUM_CHANNELS  per-channel PN mismatch, up_clk domain.
pn_oos  input  NUM_CHANNELS  per-channel PN out-of-sync, up_clk domain.
up_wreq  input  1  write request, single cycle.
up_waddr  input  14  write word address.
up_wdata  input  32  write data.
up_wack  output  1  write acknowledge.
up_rreq  input  1  read request, single cycle.
up_raddr  input  14  read word address.
up_rdata  output  32  read data; zero unless acked.
up_rack  output  1  read acknowledge.
irq  output  1  present only with UP_PN_CNT_IRQ_EN.

Behaviour:
- Decode: a request hits when addr[13:8] == ADDR_BASE[13:8]. Offset = addr[7:0].
- Register map, by offset:
  - 0x00 CTRL (RW). bit0 CLEAR: self-clearing, reads 0. bit1 FREEZE. bit2 IRQ_EN (exists only with the macro).
  - 0x01 SUMMARY (RO). bit0 = OR of all sticky err bits. bit1 = OR of current pn_oos.
  - 0x04 / 0x05 STICKY_ERR for channels 0-31 / 32-63 (W1C).
  - 0x06 / 0x07 OOS_NOW for channels 0-31 / 32-63 (RO).
  - 0x80+2i ERR_CNT[i].
  - 0x81+2i OOS_CNT[i].
  - Unimplemented offsets and channels >= NUM_CHANNELS read 0; writes to them are acked and ignored.
- Handshake: a hit request produces ack exactly one cycle later, for one cycle, with up_rdata valid in that cycle. A miss produces no ack and up_rdata = 0. Requests may arrive every cycle; each gets its own ack.
- ERR_CNT[i]: +1 each cycle pn_err[i]=1 && pn_oos[i]=0 && !FREEZE.
- OOS_CNT[i]: +1 on each rising edge of pn_oos[i] (registered previous value) && !FREEZE.
- Both counters saturate at 2^COUNTER_WIDTH-1 and never wrap.
- Counter clear:
  - A write of any data to a counter address clears that counter only.
  - Writing CTRL with CLEAR=1 clears all counters and all sticky bits in the following cycle.
  - Clear and increment in the same cycle: clear wins, result 0.
- STICKY_ERR[i]: set when pn_err[i]=1 (regardless of FREEZE). A written 1 clears it. Set and clear in the same cycle: set wins.
- FREEZE: counters hold their value; sticky bits, SUMMARY and OOS_NOW keep updating.
- Reset: up_rstn low asynchronously zeroes every counter, sticky bit, CTRL, the pn_oos history, up_wack, up_rack, up_rdata and irq.
  - Any ack pending across reset is dropped.
  - After release, the first pn_oos=1 counts as a rising edge.

Optional Feature:
UP_PN_CNT_IRQ_EN
- Defined:
  - irq port and CTRL.bit2 exist.
  - irq is registered: irq <= IRQ_EN && (|STICKY_ERR). Level output; it deasserts the cycle after the sticky bits are cleared.
- Undefined:
  - No irq port.
  - CTRL.bit2 reads 0 and writes to it are ignored.

Test Plan:
- NUM_CHANNELS=4. Hold pn_err[2]=1 for 10 cycles with pn_oos=0 -> ERR_CNT[2]=10 (read at 0x84); STICKY_ERR=0x4; SUMMARY=0x1; the other counters read 0.
- Pulse pn_oos[1] high three times -> OOS_CNT[1]=3 (0x83). Write 0x4 to 0x04 while pn_err[2] is held 1 -> sticky bit 2 stays 1.
- COUNTER_WIDTH=8 with pn_err[0] held 300 cycles -> ERR_CNT[0]=0x000000FF. Write 0 to 0x80 in a cycle with pn_err[0]=1 -> reads 0.
- Set FREEZE, then apply 5 pn_err[3] cycles -> ERR_CNT[3] unchanged, sticky bit 3 set. Write CTRL=0x1 -> all counters and sticky bits 0, CTRL reads 0.
- Back-to-back reads at ADDR_BASE+0x84 and at a miss address 0x0500 -> one rack one cycle after the first request with correct data; no rack and rdata=0 for the miss. Assert up_rstn low between request and ack -> no ack, all outputs 0.
- With UP_PN_CNT_IRQ_EN and CTRL=0x4, apply one pn_err[1] pulse -> irq=1 within 2 cycles. W1C 0x2 at 0x04 -> irq=0 the cycle after.

Source files
------------

// File: rtl/up_tpl_adc_pn_counters.sv
// Per-channel PN error / out-of-sync statistics exposed as a 256-word up register region.
// Define UP_PN_CNT_IRQ_EN to add the irq output and the CTRL.IRQ_EN bit.
module up_tpl_adc_pn_counters #(
    parameter int          NUM_CHANNELS  = 1,
    parameter int          COUNTER_WIDTH = 32,
    parameter logic [13:0] ADDR_BASE     = 14'h0600
) (
    input  logic                    up_clk,
    input  logic                    up_rstn,
    input  logic [NUM_CHANNELS-1:0] pn_err,
    input  logic [NUM_CHANNELS-1:0] pn_oos,
    input  logic                    up_wreq,
    input  logic [13:0]             up_waddr,
    input  logic [31:0]             up_wdata,
    output logic                    up_wack,
    input  logic                    up_rreq,
    input  logic [13:0]             up_raddr,
    output logic [31:0]             up_rdata,
    output logic                    up_rack
`ifdef UP_PN_CNT_IRQ_EN
    ,
    output logic                    irq
`endif
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = 1;

    logic                     wr_hit;
    logic                     rd_hit;
    logic [7:0]               wr_off;
    logic [7:0]               rd_off;
    logic                     ctrl_clear;
    logic                     ctrl_freeze;
    logic                     ctrl_irq_en;
    logic [NUM_CHANNELS-1:0]  sticky;
    logic [NUM_CHANNELS-1:0]  oos_d;
    logic [NUM_CHANNELS-1:0]  err_clr;
    logic [NUM_CHANNELS-1:0]  oos_clr;
    logic [63:0]              w1c_mask;
    logic [63:0]              sticky_ext;
    logic [63:0]              oos_ext;
    logic [31:0]              rd_val;
    logic [COUNTER_WIDTH-1:0] err_cnt [NUM_CHANNELS];
    logic [COUNTER_WIDTH-1:0] oos_cnt [NUM_CHANNELS];

    assign wr_hit = up_wreq && (up_waddr[13:8] == ADDR_BASE[13:8]);
    assign rd_hit = up_rreq && (up_raddr[13:8] == ADDR_BASE[13:8]);
    assign wr_off = up_waddr[7:0];
    assign rd_off = up_raddr[7:0];

    // Counter i lives at offset {1, i[5:0], is_oos}; CTRL.CLEAR acts one cycle after its write.
    always_comb begin
        err_clr  = '0;
        oos_clr  = '0;
        w1c_mask = '0;
        if (wr_hit && wr_off == 8'h04) w1c_mask[31:0]  = up_wdata;
        if (wr_hit && wr_off == 8'h05) w1c_mask[63:32] = up_wdata;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            err_clr[i] = ctrl_clear || (wr_hit && wr_off == {1'b1, 6'(i), 1'b0});
            oos_clr[i] = ctrl_clear || (wr_hit && wr_off == {1'b1, 6'(i), 1'b1});
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            ctrl_clear  <= 1'b0;
            ctrl_freeze <= 1'b0;
        end else if (wr_hit && wr_off == 8'h00) begin
            ctrl_clear  <= up_wdata[0];
            ctrl_freeze <= up_wdata[1];
        end else begin
            ctrl_clear  <= 1'b0;
        end
    end

`ifdef UP_PN_CNT_IRQ_EN
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            ctrl_irq_en <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (wr_hit && wr_off == 8'h00) ctrl_irq_en <= up_wdata[2];
            irq <= ctrl_irq_en && (|sticky);
        end
    end
`else
    assign ctrl_irq_en = 1'b0;
`endif

    // Clear beats increment; a sticky set from pn_err beats any clear.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            sticky <= '0;
            oos_d  <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                err_cnt[i] <= '0;
                oos_cnt[i] <= '0;
            end
        end else begin
            sticky <= (ctrl_clear ? '0 : (sticky & ~w1c_mask[NUM_CHANNELS-1:0])) | pn_err;
            oos_d  <= pn_oos;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (err_clr[i])
                    err_cnt[i] <= '0;
                else if (pn_err[i] && !pn_oos[i] && !ctrl_freeze && err_cnt[i] != CNT_MAX)
                    err_cnt[i] <= err_cnt[i] + CNT_ONE;
                if (oos_clr[i])
                    oos_cnt[i] <= '0;
                else if (pn_oos[i] && !oos_d[i] && !ctrl_freeze && oos_cnt[i] != CNT_MAX)
                    oos_cnt[i] <= oos_cnt[i] + CNT_ONE;
            end
        end
    end

    always_comb begin
        sticky_ext = '0;
        oos_ext    = '0;
        sticky_ext[NUM_CHANNELS-1:0] = sticky;
        oos_ext[NUM_CHANNELS-1:0]    = pn_oos;
        rd_val = '0;
        case (rd_off)
            8'h00: rd_val = {29'd0, ctrl_irq_en, ctrl_freeze, 1'b0};
            8'h01: rd_val = {30'd0, |pn_oos, |sticky};
            8'h04: rd_val = sticky_ext[31:0];
            8'h05: rd_val = sticky_ext[63:32];
            8'h06: rd_val = oos_ext[31:0];
            8'h07: rd_val = oos_ext[63:32];
            default: begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (rd_off == {1'b1, 6'(i), 1'b0}) rd_val[COUNTER_WIDTH-1:0] = err_cnt[i];
                    if (rd_off == {1'b1, 6'(i), 1'b1}) rd_val[COUNTER_WIDTH-1:0] = oos_cnt[i];
                end
            end
        endcase
    end

    // Outputs are OR-combined with other slaves, so rdata stays zero unless acked.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            up_wack  <= 1'b0;
            up_rack  <= 1'b0;
            up_rdata <= '0;
        end else begin
            up_wack  <= wr_hit;
            up_rack  <= rd_hit;
            up_rdata <= rd_hit ? rd_val : '0;
        end
    end

endmodule
